// File: rtl/avalon_burst_ram_agent_if.sv
// Avalon-MM burst bus between the host (SDRAM port of the arbiter) and the RAM-backed agent.
interface avalon_burst_ram_agent_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 5
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [BURST_W-1:0]  burstcount;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, byteenable, read, write, writedata, burstcount,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, read, write, writedata, burstcount,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/avalon_burst_ram_agent.sv
// RAM-backed Avalon-MM burst agent mimicking the SDRAM controller's waitrequest/readdatavalid timing.
// Optional macro WAIT_INJECT_EN adds LFSR-driven waitrequest stalls in IDLE and WR_BURST.
module avalon_burst_ram_agent #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int MEM_WORDS    = 1024,
  parameter int BURST_W      = 5,
  parameter int READ_LATENCY = 2
) (
  input logic                     clk,
  input logic                     reset_n,
  avalon_burst_ram_agent_if.slave avs
);
  localparam int BE_W     = DATA_W / 8;
  localparam int WORD_LSB = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int IDX_W    = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BURST_W-1:0] rem_q, rem_d;   // write beats left, or read issues left
  logic [BURST_W-1:0] out_q, out_d;   // read beats not yet returned to the host
  logic [IDX_W-1:0]   cmd_idx, wr_idx, rd_idx;
  logic [BURST_W-1:0] cmd_len;
  logic               stall, wait_w, wr_en, rd_en;

  logic [DATA_W-1:0]       mem [MEM_WORDS];
  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]       data_q [READ_LATENCY];

  logic unused_addr;
  assign unused_addr = ^avs.address;

  assign cmd_idx = avs.address[WORD_LSB +: IDX_W];
  assign cmd_len = (avs.burstcount == '0) ? BURST_W'(1) : avs.burstcount;

`ifdef WAIT_INJECT_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= 8'hA5;
    else          lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Reset forces waitrequest high combinationally since the state register already reads IDLE.
  assign wait_w          = !reset_n || (state_q == RD_BURST) || stall;
  assign avs.waitrequest = wait_w;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    out_d   = out_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_idx  = idx_q;
    rd_idx  = idx_q;
    unique case (state_q)
      IDLE: begin
        if (!wait_w && avs.write) begin
          wr_en  = 1'b1;
          wr_idx = cmd_idx;
          idx_d  = cmd_idx + IDX_W'(1);
          rem_d  = cmd_len - BURST_W'(1);
          if (cmd_len != BURST_W'(1)) state_d = WR_BURST;
        end else if (!wait_w && avs.read) begin
          rd_en   = 1'b1;
          rd_idx  = cmd_idx;
          idx_d   = cmd_idx + IDX_W'(1);
          rem_d   = cmd_len - BURST_W'(1);
          out_d   = cmd_len;
          state_d = RD_BURST;
        end
      end
      WR_BURST: begin
        if (!wait_w && avs.write) begin
          wr_en = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          rem_d = rem_q - BURST_W'(1);
          if (rem_q == BURST_W'(1)) state_d = IDLE;
        end
      end
      RD_BURST: begin
        if (rem_q != '0) begin
          rd_en = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          rem_d = rem_q - BURST_W'(1);
        end
        if (avs.readdatavalid) begin
          out_d = out_q - BURST_W'(1);
          if (out_q == BURST_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (avs.byteenable[b]) mem[wr_idx][8*b +: 8] <= avs.writedata[8*b +: 8];
      end
    end
  end

  // Read pipe: stage 0 is the RAM output register; data only moves with its valid so readdata holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) data_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_en;
      if (rd_en) data_q[0] <= mem[rd_idx];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign avs.readdatavalid = vld_q[READ_LATENCY-1];
  assign avs.readdata      = data_q[READ_LATENCY-1];

  a_no_rd_wr_collision: assert property (@(posedge clk) disable iff (!reset_n)
    !(state_q == IDLE && !wait_w && avs.read && avs.write));

endmodule
